polar_isqrt_stage: RTL and testbench



---
 rtl/polar_pkg.sv | 20 ++
 rtl/polar_isqrt_stage_isqrt_step.sv | 40 ++++
 rtl/polar_isqrt_stage.sv | 146 ++++++++++++++
 tb/tb_polar_isqrt_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/polar_pkg.sv
// Shared definitions for the polar-coordinate pipeline.
//   - Default widths of the squared-magnitude input, root and theta tag.
//   - State encoding of the integer square-root refinement stage.
//   - Angle constant shared by the polar front end and its consumers.
package polar_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = IN_W_DEF / 2;
    localparam int TAG_W_DEF = 8;

    // Theta code of a vertical vector (90 degrees) in the front-end angle scale.
    localparam logic [7:0] THETA_VERTICAL = 8'd90;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } isqrt_state_e;

endpackage

// File: rtl/polar_isqrt_stage_isqrt_step.sv
// isqrt_step: one iteration of the restoring digit-by-digit square root.
// Ports:
//   rem_i   - partial remainder before this step (OUT_W bits suffice here,
//             since before the final step rem <= 2*root < 2^OUT_W)
//   root_i  - partial root before this step
//   bits_i  - next two operand bits, most significant pair first
//   rem_o   - partial remainder after this step (OUT_W+1 bits)
//   root_o  - partial root after this step
module isqrt_step
    import polar_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [OUT_W-1:0] rem_i,
    input  logic [OUT_W-1:0] root_i,
    input  logic [1:0]       bits_i,
    output logic [OUT_W:0]   rem_o,
    output logic [OUT_W-1:0] root_o
);

    logic [OUT_W+1:0] trial_s;
    logic [OUT_W+1:0] test_s;
    logic             ge_s;

    // Trial subtraction of (4*root + 1) from the shifted-in remainder.
    // The new remainder always fits OUT_W+1 bits, so subtracting only the
    // low OUT_W+1 bits gives the exact result.
    always_comb begin
        trial_s = {rem_i, bits_i};
        test_s  = {root_i, 2'b01};
        ge_s    = (trial_s >= test_s);
        if (ge_s) begin
            rem_o = trial_s[OUT_W:0] - test_s[OUT_W:0];
        end else begin
            rem_o = trial_s[OUT_W:0];
        end
        root_o = {root_i[OUT_W-2:0], ge_s};
    end

endmodule

// File: rtl/polar_isqrt_stage.sv
// polar_isqrt_stage: multi-cycle floor square root of x^2+y^2, with the
// theta estimate carried alongside the result.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ena                 - global enable; low freezes every register
//   in_valid/in_ready   - input handshake (in_ready only in IDLE with ena)
//   in_sq, in_tag       - squared magnitude and theta tag
//   out_valid/out_ready - output handshake (transfer also requires ena)
//   out_root, out_rem   - floor(sqrt(in_sq)) and in_sq - out_root^2
//   out_tag             - tag captured with the sample
//   busy                - high while a sample is in CALC or DONE
// One result bit is produced per enabled cycle; the result appears OUT_W
// edges after the accept edge and is held until taken.
module polar_isqrt_stage
    import polar_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_sq,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IN_W/2-1:0]  out_root,
    output logic [IN_W/2:0]    out_rem,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int OUT_W = IN_W / 2;
    localparam int CNT_W = (OUT_W > 2) ? $clog2(OUT_W) : 1;

    isqrt_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0]    op_q, op_d;
    logic [OUT_W-1:0]   root_q, root_d;
    logic [OUT_W:0]     rem_q, rem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [OUT_W:0]     step_rem_s;
    logic [OUT_W-1:0]   step_root_s;

    // The top bit of rem_q is always zero while iterating, so only the low
    // OUT_W bits feed the step cell.
    isqrt_step #(
        .OUT_W (OUT_W)
    ) u_step (
        .rem_i  (rem_q[OUT_W-1:0]),
        .root_i (root_q),
        .bits_i (op_q[IN_W-1 -: 2]),
        .rem_o  (step_rem_s),
        .root_o (step_root_s)
    );

    // Input side is ready only when idle and enabled; no skid buffer.
    always_comb begin
        in_ready = ena && (state_q == IDLE);
    end

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        root_d  = root_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d    = in_sq;
                        tag_d   = in_tag;
                        root_d  = '0;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(OUT_W - 1);
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    root_d = step_root_s;
                    rem_d  = step_rem_s;
                    op_d   = op_q << 2;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid = valid_q;
    assign out_root  = root_q;
    assign out_rem   = rem_q;
    assign out_tag   = tag_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_polar_isqrt_stage.sv
module tb_polar_isqrt_stage;
    import polar_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sq = 16'd0;
    logic [7:0]  in_tag = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_root;
    logic [8:0]  out_rem;
    logic [7:0]  out_tag;
    logic        busy;

    int n_assert = 0;
    int n_fail = 0;

    polar_isqrt_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sq     (in_sq),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // Present a sample and wait (bounded) for the accept edge; returns at #1 after it.
    task automatic send(input logic [15:0] sq, input logic [7:0] tag, input bit hold);
        int n;
        in_sq = sq;
        in_tag = tag;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Count edges until out_valid (bounded); checks in_ready stays low meanwhile when asked.
    task automatic wait_done(output int lat, input bit chk_rdy);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1; lat++;
            if (out_valid) break;
            if (chk_rdy) chk("in_ready_low_busy", {31'd0, in_ready}, 32'd0);
        end
        chk("done_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_result(input string name, input logic [15:0] sq,
                                input int er, input int erem, input int etag);
        chk({name, "_root"}, {24'd0, out_root}, er);
        chk({name, "_rem"}, {23'd0, out_rem}, erem);
        chk({name, "_tag"}, {24'd0, out_tag}, etag);
        chk({name, "_invariant"}, out_root * out_root + out_rem, {16'd0, sq});
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("after_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("after_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [7:0] r0;
        logic [8:0] m0;
        logic [7:0] t0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_root", {24'd0, out_root}, 32'd0);
        chk("rst_rem", {23'd0, out_rem}, 32'd0);
        chk("rst_tag", {24'd0, out_tag}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        // 200 -> 14 rem 4, latency 8
        send(16'd200, 8'd1, 1'b0);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(lat, 1'b1);
        chk("lat_200", lat, 32'd8);
        check_result("sq200", 16'd200, 14, 4, 1);
        handshake();

        // 25 -> 5 rem 0, tag vertical
        send(16'd25, THETA_VERTICAL, 1'b0);
        wait_done(lat, 1'b1);
        check_result("sq25", 16'd25, 5, 0, 90);
        handshake();

        // 0 then 65535 back-to-back, in_valid held
        send(16'd0, 8'd11, 1'b1);
        in_sq = 16'd65535;
        in_tag = 8'd12;
        wait_done(lat, 1'b1);
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        check_result("sq0", 16'd0, 0, 0, 11);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_hs_valid", {31'd0, out_valid}, 32'd0);
        send(16'd65535, 8'd12, 1'b0);
        wait_done(lat, 1'b1);
        chk("lat_max", lat, 32'd8);
        check_result("sqmax", 16'd65535, 255, 510, 12);
        handshake();

        // Back-pressure: 20 cycles held, then a single transfer
        send(16'd100, 8'd7, 1'b0);
        wait_done(lat, 1'b1);
        r0 = out_root; m0 = out_rem; t0 = out_tag;
        chk("bp_root", {24'd0, r0}, 32'd10);
        chk("bp_rem", {23'd0, m0}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
            chk("bp_outputs_held", {out_root, out_rem, out_tag}, {r0, m0, t0});
        end
        handshake();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("single_transfer", {31'd0, out_valid}, 32'd0);
        end

        // ena low 5 cycles mid-CALC: latency 8+5, result unchanged
        send(16'd144, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        ena = 1'b0;
        chk("ena_low_ready", {31'd0, in_ready}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("ena_low_no_valid", {31'd0, out_valid}, 32'd0);
        ena = 1'b1;
        wait_done(lat, 1'b0);
        chk("lat_ena", lat + 8, 32'd13);
        check_result("sq144", 16'd144, 12, 0, 3);
        // ena low blocks the output transfer even with out_ready high
        ena = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ena_low_hold_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        ena = 1'b1;
        #1;
        handshake();

        // Reset during CALC iteration 3, then a fresh sample
        send(16'd200, 8'd9, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_root", {24'd0, out_root}, 32'd0);
        chk("midrst_rem", {23'd0, out_rem}, 32'd0);
        chk("midrst_tag", {24'd0, out_tag}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_idle_ready", {31'd0, in_ready}, 32'd1);
        send(16'd50, 8'd4, 1'b0);
        wait_done(lat, 1'b1);
        chk("lat_50", lat, 32'd8);
        check_result("sq50", 16'd50, 7, 1, 4);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
